shifter_arbiter: RTL and testbench

//  Shares one combinational shifter instance between two requesters (port 0: ALU

---
 rtl/shifter_arbiter.sv | 140 ++++++++++++++
 tb/tb_shifter_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_arbiter.sv
// Shares one combinational shifter between two requesters with round-robin
// arbitration. Only one operation is in flight at a time. The result is
// registered and held until the owning requester accepts it.
module shifter_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int RR_INIT_PRI = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [DATA_WIDTH-1:0] req_a0,
    input  logic [DATA_WIDTH-1:0] req_a1,
    input  logic [DATA_WIDTH-1:0] req_b0,
    input  logic [DATA_WIDTH-1:0] req_b1,
    input  logic [1:0]            req_op0,
    input  logic [1:0]            req_op1,
    output logic [1:0]            resp_valid,
    input  logic [1:0]            resp_ready,
    output logic [DATA_WIDTH-1:0] resp_result
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    // Seeding last_grant with the opposite port makes RR_INIT_PRI win the first tie.
    localparam logic INIT_LAST = (RR_INIT_PRI == 0) ? 1'b1 : 1'b0;

    state_t                r_state;
    state_t                w_nextState;
    logic                  r_owner;
    logic                  r_lastGrant;
    logic [DATA_WIDTH-1:0] r_result;

    logic                  w_grantValid;
    logic                  w_grant;
    logic                  w_canAccept;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_selA;
    logic [DATA_WIDTH-1:0] w_selB;
    logic [1:0]            w_selOp;
    logic [DATA_WIDTH-1:0] w_shiftOut;
    logic                  w_unused;

    // Only the low five bits of operand B form the shift amount.
    assign w_unused = ^{req_b0[DATA_WIDTH-1:5], req_b1[DATA_WIDTH-1:5]};

    // The shared shifter: SLL/SRL zero-fill, SRA sign-fills, reserved op yields zero.
    function automatic logic [DATA_WIDTH-1:0] doShift(
        input logic [DATA_WIDTH-1:0] a,
        input logic [4:0]            amt,
        input logic [1:0]            op
    );
        logic [DATA_WIDTH-1:0] res;
        case (op)
            2'b00:   res = a << amt;
            2'b10:   res = a >> amt;
            2'b11:   res = $signed(a) >>> amt;
            default: res = '0;
        endcase
        return res;
    endfunction

    // A new op may be taken when nothing is held, or when the held result leaves this cycle.
    assign w_canAccept = (r_state == IDLE) || (resp_ready[r_owner]);
    assign w_accept    = w_grantValid && w_canAccept;

    // Round-robin pick: a lone requester wins; on a tie the port not served last wins.
    always_comb begin
        w_grantValid = 1'b0;
        w_grant      = 1'b0;
        case (req_valid)
            2'b01: begin
                w_grantValid = 1'b1;
                w_grant      = 1'b0;
            end
            2'b10: begin
                w_grantValid = 1'b1;
                w_grant      = 1'b1;
            end
            2'b11: begin
                w_grantValid = 1'b1;
                w_grant      = ~r_lastGrant;
            end
            default: begin
                w_grantValid = 1'b0;
                w_grant      = 1'b0;
            end
        endcase
    end

    // Ready is raised only toward the granted port, and only when the slot is free.
    always_comb begin
        req_ready = 2'b00;
        if (w_accept) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    // Steer the granted port's operands into the shifter.
    always_comb begin
        w_selA  = w_grant ? req_a1  : req_a0;
        w_selB  = w_grant ? req_b1  : req_b0;
        w_selOp = w_grant ? req_op1 : req_op0;
        w_shiftOut = doShift(w_selA, w_selB[4:0], w_selOp);
    end

    // Next state: an accept always lands in RESP; a drained result with no new op goes idle.
    always_comb begin
        w_nextState = r_state;
        if (w_accept) begin
            w_nextState = RESP;
        end else if ((r_state == RESP) && resp_ready[r_owner]) begin
            w_nextState = IDLE;
        end
    end

    // State register plus held result, owner and round-robin history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_owner     <= 1'b0;
            r_lastGrant <= INIT_LAST;
            r_result    <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_result    <= w_shiftOut;
                r_owner     <= w_grant;
                r_lastGrant <= w_grant;
            end
        end
    end

    assign resp_valid  = (r_state == RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign resp_result = r_result;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed bench for shifter_arbiter: reset, each shift op, round-robin
// alternation, response backpressure, reset mid-response and in-order delivery.
module tb_shifter_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0;
    logic [31:0] req_a1;
    logic [31:0] req_b0;
    logic [31:0] req_b1;
    logic [1:0]  req_op0;
    logic [1:0]  req_op1;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_result;

    int total;
    int bad;

    shifter_arbiter #(
        .DATA_WIDTH (32),
        .RR_INIT_PRI(0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a0     (req_a0),
        .req_a1     (req_a1),
        .req_b0     (req_b0),
        .req_b1     (req_b1),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_result(resp_result)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge so registered outputs are settled.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
        req_op0 = 2'b00; req_op1 = 2'b00;
        tick;
        tick;
        rst_n = 1'b1;
        #1;
        total++;
        if (resp_valid !== 2'b00) begin
            bad++;
            $display("[TB] FAIL reset_resp_valid got=%b want=00", resp_valid);
        end
        total++;
        if (resp_result !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_result got=%h want=00000000", resp_result);
        end
        total++;
        if (req_ready !== 2'b00) begin
            bad++;
            $display("[TB] FAIL reset_req_ready got=%b want=00", req_ready);
        end
    endtask

    task automatic test_sll;
        req_valid  = 2'b01;
        req_a0     = 32'h0000_0001;
        req_b0     = 32'd4;
        req_op0    = 2'b00;
        resp_ready = 2'b01;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++;
            $display("[TB] FAIL sll_req_ready got=%b want=01", req_ready);
        end
        tick;
        req_valid = 2'b00;
        #1;
        total++;
        if (resp_valid !== 2'b01) begin
            bad++;
            $display("[TB] FAIL sll_resp_valid got=%b want=01", resp_valid);
        end
        total++;
        if (resp_result !== 32'h0000_0010) begin
            bad++;
            $display("[TB] FAIL sll_result got=%h want=00000010", resp_result);
        end
        tick;
        total++;
        if (resp_valid !== 2'b00) begin
            bad++;
            $display("[TB] FAIL sll_drain got=%b want=00", resp_valid);
        end
    endtask

    task automatic test_port1_ops;
        logic [1:0]  ops  [3];
        logic [31:0] exps [3];
        ops[0] = 2'b11; exps[0] = 32'hC000_0000;
        ops[1] = 2'b10; exps[1] = 32'h4000_0000;
        ops[2] = 2'b01; exps[2] = 32'h0000_0000;
        resp_ready = 2'b10;
        req_a1     = 32'h8000_0000;
        req_b1     = 32'h0000_0021;
        for (int i = 0; i < 3; i++) begin
            req_valid = 2'b10;
            req_op1   = ops[i];
            #1;
            total++;
            if (req_ready !== 2'b10) begin
                bad++;
                $display("[TB] FAIL p1_req_ready[%0d] got=%b want=10", i, req_ready);
            end
            tick;
            req_valid = 2'b00;
            #1;
            total++;
            if (resp_valid !== 2'b10) begin
                bad++;
                $display("[TB] FAIL p1_resp_valid[%0d] got=%b want=10", i, resp_valid);
            end
            total++;
            if (resp_result !== exps[i]) begin
                bad++;
                $display("[TB] FAIL p1_result[%0d] got=%h want=%h", i, resp_result, exps[i]);
            end
        end
        tick;
    endtask

    task automatic test_round_robin;
        logic [1:0]  wantReady;
        logic [31:0] wantRes;
        req_a0 = 32'h0000_000F; req_b0 = 32'd1; req_op0 = 2'b00;
        req_a1 = 32'hF000_0000; req_b1 = 32'd4; req_op1 = 2'b11;
        resp_ready = 2'b11;
        req_valid  = 2'b11;
        for (int i = 0; i < 6; i++) begin
            wantReady = (i % 2 == 0) ? 2'b01 : 2'b10;
            wantRes   = (i % 2 == 0) ? 32'h0000_001E : 32'hFF00_0000;
            #1;
            total++;
            if (req_ready !== wantReady) begin
                bad++;
                $display("[TB] FAIL rr_grant[%0d] got=%b want=%b", i, req_ready, wantReady);
            end
            tick;
            total++;
            if (resp_valid !== wantReady) begin
                bad++;
                $display("[TB] FAIL rr_owner[%0d] got=%b want=%b", i, resp_valid, wantReady);
            end
            total++;
            if (resp_result !== wantRes) begin
                bad++;
                $display("[TB] FAIL rr_result[%0d] got=%h want=%h", i, resp_result, wantRes);
            end
        end
        req_valid = 2'b00;
        tick;
    endtask

    task automatic test_backpressure;
        req_valid  = 2'b01;
        req_a0     = 32'h0000_1234; req_b0 = 32'd4; req_op0 = 2'b00;
        resp_ready = 2'b00;
        tick;
        req_valid  = 2'b11;
        req_a0     = 32'h0000_0003;
        req_a1     = 32'h0000_0100; req_b1 = 32'd8; req_op1 = 2'b10;
        resp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (req_ready !== 2'b00) begin
                bad++;
                $display("[TB] FAIL bp_req_ready[%0d] got=%b want=00", i, req_ready);
            end
            total++;
            if ((resp_valid !== 2'b01) || (resp_result !== 32'h0001_2340)) begin
                bad++;
                $display("[TB] FAIL bp_hold[%0d] got=%b/%h want=01/00012340", i, resp_valid, resp_result);
            end
            tick;
        end
        resp_ready = 2'b01;
        #1;
        total++;
        if (req_ready !== 2'b10) begin
            bad++;
            $display("[TB] FAIL bp_release_grant got=%b want=10", req_ready);
        end
        tick;
        req_valid  = 2'b00;
        resp_ready = 2'b11;
        #1;
        total++;
        if ((resp_valid !== 2'b10) || (resp_result !== 32'h0000_0001)) begin
            bad++;
            $display("[TB] FAIL bp_p1_result got=%b/%h want=10/00000001", resp_valid, resp_result);
        end
        tick;
    endtask

    task automatic test_reset_in_resp;
        req_valid  = 2'b01;
        req_a0     = 32'h0000_0005; req_b0 = 32'd2; req_op0 = 2'b00;
        resp_ready = 2'b00;
        tick;
        req_valid = 2'b00;
        rst_n     = 1'b0;
        tick;
        total++;
        if ((resp_valid !== 2'b00) || (resp_result !== 32'h0)) begin
            bad++;
            $display("[TB] FAIL rst_resp got=%b/%h want=00/00000000", resp_valid, resp_result);
        end
        rst_n     = 1'b1;
        req_valid = 2'b11;
        req_a1    = 32'h0000_0008; req_b1 = 32'd3; req_op1 = 2'b10;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++;
            $display("[TB] FAIL rst_first_grant got=%b want=01", req_ready);
        end
        tick;
        req_valid  = 2'b00;
        resp_ready = 2'b11;
        #1;
        total++;
        if ((resp_valid !== 2'b01) || (resp_result !== 32'h0000_0014)) begin
            bad++;
            $display("[TB] FAIL rst_first_result got=%b/%h want=01/00000014", resp_valid, resp_result);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int sent;
        int got;
        logic [31:0] want;
        sent = 0;
        got  = 0;
        for (int i = 0; i < 10; i++) begin
            resp_ready = {1'b0, (i % 2 == 0)};
            req_valid  = 2'b01;
            req_a0     = 32'(sent + 1);
            req_b0     = 32'd1;
            req_op0    = 2'b00;
            #1;
            if (resp_valid[0] && resp_ready[0]) begin
                want = 32'((got + 1) * 2);
                total++;
                if (resp_result !== want) begin
                    bad++;
                    $display("[TB] FAIL b2b_order[%0d] got=%h want=%h", got, resp_result, want);
                end
                got++;
            end
            if (req_ready[0]) sent++;
            tick;
        end
        req_valid  = 2'b00;
        resp_ready = 2'b01;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (resp_valid[0]) begin
                want = 32'((got + 1) * 2);
                total++;
                if (resp_result !== want) begin
                    bad++;
                    $display("[TB] FAIL b2b_drain[%0d] got=%h want=%h", got, resp_result, want);
                end
                got++;
            end
            tick;
        end
        total++;
        if ((got !== sent) || (sent < 4)) begin
            bad++;
            $display("[TB] FAIL b2b_count delivered=%0d want=%0d (sent>=4)", got, sent);
        end
        total++;
        if (resp_valid !== 2'b00) begin
            bad++;
            $display("[TB] FAIL b2b_idle got=%b want=00", resp_valid);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        total = 0;
        bad   = 0;
        test_reset;
        test_sll;
        test_port1_ops;
        test_round_robin;
        test_backpressure;
        test_reset_in_resp;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
